// File: rtl/sdram_port_arbiter.sv
// Arbitrates a byte-write loader and a level-request tape reader onto one SDRAM controller port.
// Optional last-read cache enabled by defining SDRAM_PORT_ARBITER_RDCACHE_EN.
//
// state | meaning
// IDLE  | pick work: buffered write first, then a read request
// WRITE | write issued, waiting for mem_ready or timeout
// READ  | read issued, waiting for mem_ready or timeout
// ACK   | rd_ack pulse, then back to IDLE
module sdram_port_arbiter #(
   parameter int AW      = 25,
   parameter int TIMEOUT = 1023
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   output logic          wr_busy,
   input  logic          rd_req,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          rd_ack,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_din,
   output logic          mem_we,
   output logic          mem_rd,
   input  logic [7:0]    mem_dout,
   input  logic          mem_ready,
   output logic          err
);

   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;

   state_t          state_q, state_d;
   logic            buf_full_q, buf_full_d;
   logic [AW-1:0]   buf_addr_q, buf_addr_d;
   logic [7:0]      buf_data_q, buf_data_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [7:0]      mem_din_q, mem_din_d;
   logic            mem_we_q, mem_we_d;
   logic            mem_rd_q, mem_rd_d;
   logic [7:0]      rd_data_q, rd_data_d;
   logic            rd_ack_q, rd_ack_d;
   logic            err_q, err_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            drain;
   logic            cache_hit;
   logic [7:0]      cache_data;

`ifdef SDRAM_PORT_ARBITER_RDCACHE_EN
   logic            cache_vld_q, cache_vld_d;
   logic [AW-1:0]   cache_addr_q, cache_addr_d;
   logic [7:0]      cache_data_q, cache_data_d;

   assign cache_hit  = cache_vld_q && (cache_addr_q == rd_addr);
   assign cache_data = cache_data_q;

   // A write issue to the cached address kills the entry, even if the fill raced with it.
   always_comb begin
      cache_vld_d  = cache_vld_q;
      cache_addr_d = cache_addr_q;
      cache_data_d = cache_data_q;
      if (state_q == READ && mem_ready) begin
         cache_vld_d  = 1'b1;
         cache_addr_d = mem_addr_q;
         cache_data_d = mem_dout;
      end
      if (state_q == IDLE && buf_full_q && buf_addr_q == cache_addr_q)
         cache_vld_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cache_vld_q  <= 1'b0;
         cache_addr_q <= '0;
         cache_data_q <= '0;
      end else begin
         cache_vld_q  <= cache_vld_d;
         cache_addr_q <= cache_addr_d;
         cache_data_q <= cache_data_d;
      end
   end
`else
   assign cache_hit  = 1'b0;
   assign cache_data = 8'h00;
`endif

   always_comb begin
      state_d    = state_q;
      buf_full_d = buf_full_q;
      buf_addr_d = buf_addr_q;
      buf_data_d = buf_data_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_we_d   = 1'b0;
      mem_rd_d   = 1'b0;
      rd_data_d  = rd_data_q;
      rd_ack_d   = 1'b0;
      err_d      = err_q;
      tmr_d      = tmr_q;
      drain      = 1'b0;

      case (state_q)
         IDLE: begin
            if (buf_full_q) begin
               drain      = 1'b1;
               state_d    = WRITE;
               mem_we_d   = 1'b1;
               mem_addr_d = buf_addr_q;
               mem_din_d  = buf_data_q;
               buf_full_d = 1'b0;
               tmr_d      = TMR_LOAD;
            end else if (rd_req && !wr_req) begin
               // A write strobe this cycle lands in the buffer and must win next cycle.
               if (cache_hit) begin
                  state_d   = ACK;
                  rd_ack_d  = 1'b1;
                  rd_data_d = cache_data;
               end else begin
                  state_d    = READ;
                  mem_rd_d   = 1'b1;
                  mem_addr_d = rd_addr;
                  tmr_d      = TMR_LOAD;
               end
            end
         end
         WRITE: begin
            if (mem_ready) begin
               state_d = IDLE;
            end else if (tmr_q == '0) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         READ: begin
            if (mem_ready) begin
               state_d   = ACK;
               rd_ack_d  = 1'b1;
               rd_data_d = mem_dout;
            end else if (tmr_q == '0) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         ACK: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (wr_req) begin
         if (!buf_full_q || drain) begin
            buf_full_d = 1'b1;
            buf_addr_d = wr_addr;
            buf_data_d = wr_data;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         buf_full_q <= 1'b0;
         buf_addr_q <= '0;
         buf_data_q <= '0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         mem_we_q   <= 1'b0;
         mem_rd_q   <= 1'b0;
         rd_data_q  <= '0;
         rd_ack_q   <= 1'b0;
         err_q      <= 1'b0;
         tmr_q      <= '0;
      end else begin
         state_q    <= state_d;
         buf_full_q <= buf_full_d;
         buf_addr_q <= buf_addr_d;
         buf_data_q <= buf_data_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         mem_we_q   <= mem_we_d;
         mem_rd_q   <= mem_rd_d;
         rd_data_q  <= rd_data_d;
         rd_ack_q   <= rd_ack_d;
         err_q      <= err_d;
         tmr_q      <= tmr_d;
      end
   end

   assign wr_busy  = buf_full_q;
   assign mem_addr = mem_addr_q;
   assign mem_din  = mem_din_q;
   assign mem_we   = mem_we_q;
   assign mem_rd   = mem_rd_q;
   assign rd_data  = rd_data_q;
   assign rd_ack   = rd_ack_q;
   assign err      = err_q;

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL provide parameter AW, default 25, the memory address width in bits.
REQ-002 SHALL provide parameter TIMEOUT, default 1023, the maximum number of cycles to wait for mem_ready before aborting.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, the reset; asynchronous and active-low.
REQ-005 SHALL have port wr_req, input, 1 bit, a write strobe from the loader (one cycle per byte).
REQ-006 SHALL have port wr_addr, input, AW bits, plus port wr_data, input, 8 bits, both sampled with wr_req.
REQ-007 SHALL have port wr_busy, output, 1 bit, high while the write buffer is full.
REQ-008 SHALL have port rd_req, input, 1 bit, a level read request from the tape reader, held until rd_ack.
REQ-009 SHALL have port rd_addr, input, AW bits, which must remain stable while rd_req is high.
REQ-010 SHALL have port rd_data, output, 8 bits, plus port rd_ack, output, 1 bit, a one-cycle data-valid pulse.
REQ-011 SHALL have ports mem_addr (output, AW), mem_din (output, 8), mem_we (output, 1), mem_rd (output, 1), mem_dout (input, 8) and mem_ready (input, 1), forming the SDRAM controller port.
REQ-012 SHALL have port err, output, 1 bit, a sticky flag for timeout or dropped write.

Function
REQ-013 SHALL hold a one-entry write buffer; wr_req with the buffer empty loads it and sets wr_busy on the next cycle.
REQ-014 SHALL ignore wr_req while the buffer is full and not draining, and SHALL set err in that case.
REQ-015 SHALL accept a wr_req that occurs in the same cycle the buffer is issued to memory, with no drop.
REQ-016 SHALL implement states IDLE, WRITE, READ and ACK.
- IDLE: if the buffer is full, go to WRITE; otherwise, if rd_req is high, go to READ.
REQ-017 SHALL give writes strict priority when a buffered write and rd_req are present together in IDLE.
REQ-018 On entering WRITE or READ, SHALL drive mem_we or mem_rd high for exactly one cycle, with mem_addr and mem_din valid and held until the state exits.
REQ-019 In WRITE, SHALL return to IDLE on mem_ready and free the buffer on the issue cycle.
REQ-020 In READ, SHALL latch mem_dout into rd_data on mem_ready and go to ACK.
REQ-021 In ACK, SHALL pulse rd_ack for one cycle and return to IDLE; it SHALL NOT issue a new read until rd_req has been sampled again in IDLE.
REQ-022 SHALL meet read latency: rd_req sampled in IDLE at cycle N gives mem_rd at N+1; mem_ready at cycle M gives rd_ack at M+1.
REQ-023 SHALL abort WRITE or READ to IDLE, set err and emit no rd_ack if mem_ready is absent for TIMEOUT cycles; an aborted write is discarded.
REQ-024 SHALL hold rd_data until the next latched read; err clears only on reset.

Reset
REQ-025 On reset_n low, SHALL immediately enter IDLE and drive mem_we, mem_rd, rd_ack, wr_busy and err to 0, and rd_data, mem_addr and mem_din to 0, with the buffer emptied.
REQ-026 SHALL abandon any in-flight access on reset mid-operation; after release, it SHALL issue nothing until a new request arrives.

Configuration
REQ-027 When SDRAM_PORT_ARBITER_RDCACHE_EN is defined, SHALL keep the last read address/data pair (invalidated by reset or by any write to that address).
- A rd_req hitting a valid entry in IDLE SHALL produce rd_ack on the next cycle without asserting mem_rd.
- When the macro is undefined, every read SHALL access memory.

Verification
REQ-028 Write then read: wr_req with addr 0x000100 and data 0xA5, then rd_req at 0x000100 with mem_ready 3 cycles later -> mem_we pulse, then rd_data = 0xA5 and rd_ack at M+1.
REQ-029 Collision: wr_req and rd_req in the same IDLE cycle -> mem_we issued first, mem_rd issued only after the write's mem_ready.
REQ-030 Overflow: with mem_ready stalled, three wr_req strobes -> second accepted at issue, third dropped, err = 1.
REQ-031 Timeout: with TIMEOUT = 15 and mem_ready never asserted on a read -> return to IDLE after 15 cycles, err = 1, no rd_ack.
REQ-032 Reset mid-READ: reset_n low for 1 cycle -> all outputs 0 and no rd_ack after release.
REQ-033 With the macro defined, a repeated read of 0x000200 -> second rd_ack one cycle after rd_req and no mem_rd; a write to 0x000200 followed by a read -> mem_rd issued.
